// File: rtl/bam_scope_capture.sv
// bam_scope_capture: triggered 1-bit capture of the BAM generator output
// into a frozen record read back by the VGA renderer one column at a time.
module bam_scope_capture #(
    parameter int DEPTH   = 640,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_enable,
    input  logic              i_signal,
    input  logic [2:0]        i_decim,
    input  logic              i_rearm,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_trig_timeout
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        decim_l;
    logic [6:0]        presc;
    logic [6:0]        presc_max;
    logic [TW-1:0]     tcnt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] waddr;
    logic              s_prev;
    logic              trig_to;
    logic              rd_data;
    logic              tick;
    logic              arm;
    logic              live;
    logic              rise;
    logic              tmo;
    logic              trig;
    logic              cap;
    logic              last;
    logic              we;
    logic              mem [DEPTH];

    assign presc_max = 7'((8'd1 << decim_l) - 8'd1);
    assign tick      = o_busy && (presc == presc_max);
    assign arm       = i_enable & i_rearm;
    assign live      = i_enable & ~i_rearm;
    assign rise      = i_signal & ~s_prev;
    assign tmo       = (tcnt == TW'(TIMEOUT - 1));
    assign trig      = live & tick & (state == ARMED) & (rise | tmo);
    assign cap       = live & tick & (state == CAPTURE);
    assign last      = (wptr == ADDR_W'(DEPTH - 1));
    assign we        = trig | cap;
    assign waddr     = (state == ARMED) ? '0 : wptr;

    assign o_rd_data      = rd_data;
    assign o_trig_timeout = trig_to;

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: disable wins over rearm, rearm restarts from any state
    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = IDLE;
        end else if (i_rearm) begin
            state_nxt = ARMED;
        end else begin
            unique case (state)
                ARMED:   if (trig) state_nxt = CAPTURE;
                CAPTURE: if (cap && last) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        o_busy = (state == ARMED) || (state == CAPTURE);
        o_done = (state == DONE);
    end

    // Prescaler, timeout, write pointer and edge detect
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            decim_l <= '0;
            presc   <= '0;
            tcnt    <= '0;
            wptr    <= '0;
            s_prev  <= 1'b0;
            trig_to <= 1'b0;
        end else if (arm) begin
            decim_l <= i_decim;
            presc   <= '0;
            tcnt    <= '0;
            wptr    <= '0;
            s_prev  <= 1'b1;
            trig_to <= 1'b0;
        end else if (i_enable && o_busy) begin
            presc <= tick ? '0 : presc + 7'd1;
            if (tick && state == ARMED) begin
                s_prev <= i_signal;
                if (trig) begin
                    wptr <= ADDR_W'(1);
                    if (!rise) trig_to <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
            if (cap) wptr <= wptr + 1'b1;
        end
    end

    // Sample buffer write port (contents survive reset)
    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= i_signal;
    end

    // Registered read port; out-of-range columns read as 0
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) rd_data <= 1'b0;
        else rd_data <= ({1'b0, i_rd_addr} < DEPTH_C) ? mem[i_rd_addr] : 1'b0;
    end

endmodule

// File: tb/tb_bam_scope_capture.sv
// tb_bam_scope_capture: directed bench for the BAM scope capture block,
// read-back values checked through an expected-value queue.
module tb_bam_scope_capture;

    logic       i_clk = 1'b0;
    logic       i_arst = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_signal = 1'b0;
    logic [2:0] i_decim = 3'd0;
    logic       i_rearm = 1'b0;
    logic [9:0] i_rd_addr = 10'd0;
    logic       o_rd_data;
    logic       o_busy;
    logic       o_done;
    logic       o_trig_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int sig_cnt  = 0;
    bit gen_on   = 1'b0;
    bit b;
    bit exp_mem [640];
    bit exp_q [$];

    bam_scope_capture #(
        .DEPTH(640),
        .ADDR_W(10),
        .TIMEOUT(1024)
    ) dut (
        .i_clk(i_clk),
        .i_arst(i_arst),
        .i_enable(i_enable),
        .i_signal(i_signal),
        .i_decim(i_decim),
        .i_rearm(i_rearm),
        .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_trig_timeout(o_trig_timeout)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #900us;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        if (gen_on) begin
            sig_cnt++;
            i_signal = sig_cnt[3];
        end
    endtask

    task automatic arm();
        i_rearm = 1'b1;
        step();
        i_rearm = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        while (o_done !== 1'b1 && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    task automatic rd_all();
        for (int a = 0; a < 640; a++) begin
            i_rd_addr = 10'(a);
            exp_q.push_back(exp_mem[a]);
            step();
            chk($sformatf("rd[%0d]", a), o_rd_data, exp_q.pop_front());
        end
    endtask

    initial begin
        // reset state
        step();
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_tto", o_trig_timeout, 0);
        chk("rst_rd", o_rd_data, 0);
        i_arst = 1'b0;
        step();

        // 1: decim 0, rise after 10 low clocks
        i_enable = 1'b1;
        i_signal = 1'b0;
        arm();
        chk("t1_busy", o_busy, 1);
        repeat (10) step();
        i_signal = 1'b1;
        wait_done(2000, n);
        chk("t1_len", n, 640);
        chk("t1_tto", o_trig_timeout, 0);
        for (int a = 0; a < 640; a++) exp_mem[a] = 1'b1;
        rd_all();

        // 2: decim 3, signal toggles every 8 clocks
        i_decim = 3'd3;
        i_signal = 1'b0;
        sig_cnt = 0;
        gen_on = 1'b1;
        arm();
        wait_done(6000, n);
        gen_on = 1'b0;
        chk("t2_len", n, 5136);
        chk("t2_tto", o_trig_timeout, 0);
        for (int a = 0; a < 640; a++) exp_mem[a] = (a % 2 == 0);
        rd_all();

        // 3: signal held high -> auto-trigger
        i_decim = 3'd0;
        i_signal = 1'b1;
        step();
        arm();
        wait_done(3000, n);
        chk("t3_len", n, 1663);
        chk("t3_tto", o_trig_timeout, 1);
        for (int a = 0; a < 640; a++) exp_mem[a] = 1'b1;
        rd_all();

        // 4: enable dropped at sample 300
        i_signal = 1'b0;
        arm();
        repeat (3) step();
        i_signal = 1'b1;
        step();
        chk("t4_busy0", o_busy, 1);
        i_signal = 1'b0;
        repeat (299) step();
        chk("t4_busy1", o_busy, 1);
        i_enable = 1'b0;
        step();
        chk("t4_busy2", o_busy, 0);
        chk("t4_done", o_done, 0);
        chk("t4_tto", o_trig_timeout, 0);
        exp_mem[0] = 1'b1;
        for (int a = 1; a < 300; a++) exp_mem[a] = 1'b0;
        rd_all();

        // 5: rearm after enable, random record
        i_enable = 1'b1;
        i_signal = 1'b0;
        arm();
        chk("t5_busy", o_busy, 1);
        repeat (3) step();
        i_signal = 1'b1;
        exp_mem[0] = 1'b1;
        step();
        for (int k = 1; k < 640; k++) begin
            b = 1'($urandom_range(0, 1));
            i_signal = b;
            exp_mem[k] = b;
            if (k == 639) chk("t5_pre", o_done, 0);
            step();
        end
        chk("t5_done", o_done, 1);
        rd_all();
        i_rd_addr = 10'd5;
        exp_q.push_back(exp_mem[5]);
        step();
        chk("t5_rd5", o_rd_data, exp_q.pop_front());
        i_rd_addr = 10'd700;
        exp_q.push_back(1'b0);
        step();
        chk("t5_rd700", o_rd_data, exp_q.pop_front());

        // rearm mid-capture
        i_signal = 1'b0;
        arm();
        repeat (3) step();
        i_signal = 1'b1;
        step();
        repeat (9) step();
        chk("t5_cap", o_busy, 1);
        i_signal = 1'b0;
        arm();
        chk("t5_rbusy", o_busy, 1);
        chk("t5_rdone", o_done, 0);
        repeat (3) step();
        i_signal = 1'b1;
        step();
        i_signal = 1'b0;
        repeat (638) step();
        chk("t5_rpre", o_done, 0);
        step();
        chk("t5_rfin", o_done, 1);
        exp_mem[0] = 1'b1;
        for (int a = 1; a < 640; a++) exp_mem[a] = 1'b0;
        rd_all();

        // 6: async reset mid-capture
        i_rd_addr = 10'd0;
        step();
        chk("t6_rd_pre", o_rd_data, 1);
        arm();
        repeat (3) step();
        i_signal = 1'b1;
        step();
        repeat (5) step();
        chk("t6_busy", o_busy, 1);
        #2 i_arst = 1'b1;
        #1;
        chk("t6_busy_rst", o_busy, 0);
        chk("t6_done_rst", o_done, 0);
        chk("t6_tto_rst", o_trig_timeout, 0);
        chk("t6_rd_rst", o_rd_data, 0);
        step();
        i_arst = 1'b0;
        repeat (3) step();
        chk("t6_idle", o_busy, 0);

        // decim change while busy is ignored
        i_decim = 3'd1;
        i_signal = 1'b1;
        arm();
        i_decim = 3'd0;
        wait_done(5000, n);
        chk("t6_len", n, 3326);
        chk("t6_tto", o_trig_timeout, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
